zrl_decoder: RTL and testbench

Inverse of the ZRL encoder. The block accepts the packed, MSB-first ZRL bitstream as 64-bit words with valid/ready, sop and eop. It re-aligns variable-length codewords in an internal bit buffer and reconstructs one 64-bit data word per codeword. It sits on the decompression path between the stream unpacker and the bit-plane reconstruction stage.

---
 rtl/zrl_pkg.sv | 48 ++++
 rtl/zrl_cw_decode.sv | 47 ++++
 rtl/zrl_decoder.sv | 161 ++++++++++++++++
 tb/tb_zrl_decoder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zrl_pkg.sv
// Shared ZRL codeword definitions: prefixes, codeword lengths, lane selects and decoder states.
// The encoder is expected to draw its constants from here as well.
package zrl_pkg;

    localparam logic [6:0] LEN_HDR   = 7'd2;
    localparam logic [6:0] LEN_ZERO  = 7'd6;
    localparam logic [6:0] LEN_ONE   = 7'd21;
    localparam logic [6:0] LEN_L0    = 7'd22;
    localparam logic [6:0] LEN_TWO   = 7'd36;
    localparam logic [6:0] LEN_THREE = 7'd52;
    localparam logic [6:0] LEN_RAW   = 7'd66;

    localparam logic [3:0] PLEN_RAW  = 4'd2;
    localparam logic [3:0] PLEN_FOUR = 4'd4;
    localparam logic [3:0] PLEN_FIVE = 4'd5;
    localparam logic [3:0] PLEN_SIX  = 4'd6;

    localparam logic [1:0] PFX_RAW = 2'b11;
    localparam logic [4:0] PFX_L1  = 5'b00001;
    localparam logic [4:0] PFX_L2  = 5'b00010;
    localparam logic [4:0] PFX_L3  = 5'b00011;
    localparam logic [5:0] PFX_L0  = 6'b000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL
    } zrl_state_e;

    // Lane mask {L3,L2,L1,L0} carried by each 4-bit prefix class.
    function automatic logic [3:0] lanes_of_pfx4(input logic [3:0] pfx);
        case (pfx)
            4'b0010: return 4'b0011;
            4'b0011: return 4'b0101;
            4'b0100: return 4'b1001;
            4'b0101: return 4'b0110;
            4'b0110: return 4'b1010;
            4'b0111: return 4'b1100;
            4'b1000: return 4'b0111;
            4'b1001: return 4'b1011;
            4'b1010: return 4'b1101;
            4'b1011: return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/zrl_cw_decode.sv
// Classifies the codeword at the head of the bit buffer: total length, lane mask and
// bit offset of the payload. In HEAD mode the leading two bits are the packet header.
module zrl_cw_decode
    import zrl_pkg::*;
(
    input  logic [7:0] top,
    input  logic       head,
    output logic [6:0] len,
    output logic [3:0] mask,
    output logic [3:0] offset
);

    logic [5:0] pfx;
    logic [3:0] plen;
    logic [6:0] body_len;

    always_comb begin
        pfx      = head ? top[5:0] : top[7:2];
        plen     = PLEN_SIX;
        body_len = LEN_ZERO;
        mask     = 4'b0000;
        if (pfx[5:4] == PFX_RAW) begin
            plen     = PLEN_RAW;
            body_len = LEN_RAW;
            mask     = 4'b1111;
        end else if (pfx[5:3] != 3'b000) begin
            plen     = PLEN_FOUR;
            body_len = pfx[5] ? LEN_THREE : LEN_TWO;
            mask     = lanes_of_pfx4(pfx[5:2]);
        end else if (pfx[5:1] == PFX_L2 || pfx[5:1] == PFX_L3) begin
            plen     = PLEN_FIVE;
            body_len = LEN_ONE;
            mask     = pfx[1] ? 4'b1000 : 4'b0100;
        end else if (pfx[5:1] == PFX_L1) begin
            plen     = PLEN_FIVE;
            body_len = LEN_ONE;
            mask     = 4'b0010;
        end else if (pfx == PFX_L0) begin
            plen     = PLEN_SIX;
            body_len = LEN_L0;
            mask     = 4'b0001;
        end
        len    = head ? body_len + LEN_HDR : body_len;
        offset = head ? plen + LEN_HDR[3:0] : plen;
    end

endmodule

// File: rtl/zrl_decoder.sv
// ZRL stream decoder: re-aligns the packed MSB-first bitstream in a left-aligned bit
// buffer and emits one reconstructed 64-bit word per codeword.
module zrl_decoder
    import zrl_pkg::*;
#(
    parameter int BUF_W = 136
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_sop_i,
    input  logic        in_eop_i,
    input  logic [6:0]  in_last_bits_i,
    output logic [63:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_sop_o,
    output logic        out_eop_o,
    output logic        err_o
);

    localparam logic [7:0] FILL_MAX_IN = 8'(BUF_W - 64);

    zrl_state_e       state_q, state_d;
    logic [BUF_W-1:0] bits_q, bits_d;
    logic [7:0]       fill_q, fill_d;
    logic             eop_seen_q, eop_seen_d;
    logic [63:0]      out_data_q;
    logic             out_valid_q, out_sop_q, out_eop_q, err_q;

    logic [6:0]       cw_len;
    logic [3:0]       cw_mask, cw_off;
    logic [7:0]       need, consumed, remain, add;
    logic             is_head, draining, in_ready, accept, out_free, enough;
    logic             trunc_err, sop_err, drop_err, err, decode, load, last_cw;
    logic [63:0]      word_mask;
    logic [BUF_W-1:0] aligned, ins, pay_win;
    logic [63:0]      payload;

    // Scatter the packed payload (highest present lane first) into lane positions.
    function automatic logic [63:0] expand_lanes(input logic [3:0] mask, input logic [63:0] packed_lanes);
        logic [63:0] word;
        logic [63:0] rest;
        word = '0;
        rest = packed_lanes;
        for (int lane = 3; lane >= 0; lane--) begin
            if (mask[lane]) begin
                word[lane*16 +: 16] = rest[63:48];
                rest = rest << 16;
            end
        end
        return word;
    endfunction

    zrl_cw_decode u_cw_decode (
        .top    (bits_q[BUF_W-1 -: 8]),
        .head   (state_q == ST_HEAD),
        .len    (cw_len),
        .mask   (cw_mask),
        .offset (cw_off)
    );

    assign need    = {1'b0, cw_len};
    assign pay_win = bits_q << cw_off;
    assign payload = pay_win[BUF_W-1 -: 64];

    always_comb begin
        is_head   = (state_q == ST_HEAD);
        // A sop+eop word leaves HEAD already holding the whole packet, so it drains like TAIL.
        draining  = (state_q == ST_TAIL) || (is_head && eop_seen_q);
        in_ready  = !draining && (fill_q <= FILL_MAX_IN);
        accept    = in_valid_i && in_ready;
        out_free  = !out_valid_q || out_ready_i;
        enough    = (fill_q >= (is_head ? 8'd8 : 8'd6)) && (fill_q >= need);
        trunc_err = draining && (fill_q != 8'd0) && (fill_q < need);
        sop_err   = accept && in_sop_i && (state_q == ST_HEAD || state_q == ST_BODY);
        drop_err  = accept && !in_sop_i && (state_q == ST_IDLE);
        err       = trunc_err || sop_err || drop_err;
        decode    = (state_q != ST_IDLE) && enough && out_free && !sop_err;
        load      = accept && !err;
        last_cw   = decode && draining && (fill_q == need);

        consumed  = decode ? need : 8'd0;
        remain    = fill_q - consumed;
        add       = !load ? 8'd0 : (in_eop_i ? {1'b0, in_last_bits_i} : 8'd64);
        fill_d    = remain + add;
        // Bits past last_bits are zeroed so the region below fill stays clean for OR-insertion.
        word_mask = in_eop_i ? ~(64'hFFFF_FFFF_FFFF_FFFF >> in_last_bits_i) : 64'hFFFF_FFFF_FFFF_FFFF;
        aligned   = bits_q << consumed;
        ins       = {in_data_i & word_mask, {(BUF_W-64){1'b0}}} >> remain;
        bits_d    = load ? (aligned | ins) : aligned;

        state_d    = state_q;
        eop_seen_d = eop_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_HEAD;
                    eop_seen_d = in_eop_i;
                end
            end
            ST_HEAD: begin
                if (load && in_eop_i) eop_seen_d = 1'b1;
                if (last_cw)          state_d = ST_IDLE;
                else if (decode)      state_d = eop_seen_d ? ST_TAIL : ST_BODY;
            end
            ST_BODY: begin
                if (load && in_eop_i) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                if (last_cw) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (err) begin
            state_d    = ST_IDLE;
            eop_seen_d = 1'b0;
            fill_d     = 8'd0;
            bits_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fill_q      <= 8'd0;
            bits_q      <= '0;
            eop_seen_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            bits_q     <= bits_d;
            eop_seen_q <= eop_seen_d;
            err_q      <= err;
            if (decode) begin
                out_valid_q <= 1'b1;
                out_data_q  <= expand_lanes(cw_mask, payload);
                out_sop_q   <= is_head;
                out_eop_q   <= last_cw;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready_o  = in_ready;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_sop_o   = out_sop_q;
    assign out_eop_o   = out_eop_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_zrl_decoder.sv
// Self-checking bench for zrl_decoder: an independent ZRL encoder builds the streams and a
// scoreboard queue holds the expected decoded words.
module tb_zrl_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        in_sop_i = 1'b0;
    logic        in_eop_i = 1'b0;
    logic [6:0]  in_last_bits_i = '0;
    logic [63:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic        out_sop_o;
    logic        out_eop_o;
    logic        err_o;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t        exp_q[$];
    bit          stream_q[$];
    logic [63:0] pkt_words[$];

    zrl_decoder #(.BUF_W(136)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_sop_i       (in_sop_i),
        .in_eop_i       (in_eop_i),
        .in_last_bits_i (in_last_bits_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_sop_o      (out_sop_o),
        .out_eop_o      (out_eop_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every output transfer is popped against the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_o && out_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output got data=%h sop=%b eop=%b, want no output",
                         out_data_o, out_sop_o, out_eop_o);
            end else begin
                e = exp_q.pop_front();
                if ({out_data_o, out_sop_o, out_eop_o} !== e) begin
                    n_miss++;
                    $display("FAIL output got data=%h sop=%b eop=%b, want data=%h sop=%b eop=%b",
                             out_data_o, out_sop_o, out_eop_o, e.data, e.sop, e.eop);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [63:0] d, input logic sop, input logic eop);
        exp_t e;
        e.data = d;
        e.sop  = sop;
        e.eop  = eop;
        exp_q.push_back(e);
    endtask

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) stream_q.push_back(v[b]);
    endtask

    task automatic encode_word(input logic [63:0] d);
        logic [3:0] m;
        logic [5:0] pfx;
        int         plen;
        for (int k = 0; k < 4; k++) m[k] = (d[16*k +: 16] != 16'h0);
        plen = 4;
        case (m)
            4'h0: begin pfx = 6'b000000; plen = 6; end
            4'h1: begin pfx = 6'b000001; plen = 6; end
            4'h2: begin pfx = 6'b000001; plen = 5; end
            4'h4: begin pfx = 6'b000010; plen = 5; end
            4'h8: begin pfx = 6'b000011; plen = 5; end
            4'h3: pfx = 6'b0010;
            4'h5: pfx = 6'b0011;
            4'h9: pfx = 6'b0100;
            4'h6: pfx = 6'b0101;
            4'hA: pfx = 6'b0110;
            4'hC: pfx = 6'b0111;
            4'h7: pfx = 6'b1000;
            4'hB: pfx = 6'b1001;
            4'hD: pfx = 6'b1010;
            4'hE: pfx = 6'b1011;
            default: begin pfx = 6'b000011; plen = 2; end
        endcase
        push_bits({58'b0, pfx}, plen);
        for (int k = 3; k >= 0; k--)
            if (m[k]) push_bits({48'b0, d[16*k +: 16]}, 16);
    endtask

    task automatic build_packet(input logic mark_eop);
        int last;
        last = pkt_words.size() - 1;
        stream_q.delete();
        push_bits(64'h1, 2);
        foreach (pkt_words[i]) begin
            encode_word(pkt_words[i]);
            push_exp(pkt_words[i], i == 0, mark_eop && (i == last));
        end
    endtask

    task automatic drive_word(input logic [63:0] w, input logic sop, input logic eop, input logic [6:0] lb);
        int   t;
        logic rdy;
        t   = 0;
        rdy = 1'b0;
        in_data_i = w; in_sop_i = sop; in_eop_i = eop; in_last_bits_i = lb; in_valid_i = 1'b1;
        while (!rdy && t < 200) begin
            @(negedge clk);
            rdy = in_ready_o;
            @(posedge clk);
            t++;
        end
        #1 in_valid_i = 1'b0;
        if (!rdy) begin
            n_vec++;
            n_miss++;
            $display("FAIL input_accept got ready=0 for %0d cycles, want 1", t);
        end
    endtask

    task automatic send_stream();
        int          n;
        int          idx;
        int          nb;
        logic [63:0] w;
        n   = stream_q.size();
        idx = 0;
        while (idx < n) begin
            w  = '0;
            nb = (n - idx > 64) ? 64 : n - idx;
            for (int b = 0; b < nb; b++) w[63-b] = stream_q[idx+b];
            drive_word(w, idx == 0, idx + nb == n, 7'(nb));
            idx += nb;
        end
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({out_valid_o, out_sop_o, out_eop_o, err_o, out_data_o} !== 68'h0) begin
            n_miss++;
            $display("FAIL reset_outputs got v=%b s=%b e=%b err=%b d=%h, want all 0",
                     out_valid_o, out_sop_o, out_eop_o, err_o, out_data_o);
        end
        n_vec++;
        if (in_ready_o !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_ready got %b, want 1", in_ready_o);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid_o, err_o} !== 2'b00) begin
            n_miss++;
            $display("FAIL post_reset_idle got valid=%b err=%b, want 0 0", out_valid_o, err_o);
        end
    endtask

    task automatic test_zero_packet();
        @(posedge clk); #1;
        push_exp(64'h0, 1'b1, 1'b1);
        drive_word(64'h4000_0000_0000_0000, 1'b1, 1'b1, 7'd8);
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL zero_packet_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_l0_packet();
        @(posedge clk); #1;
        push_exp(64'h0000_0000_0000_1234, 1'b1, 1'b1);
        drive_word(64'h4112_3400_0000_0000, 1'b1, 1'b1, 7'd24);
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL l0_packet_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_raw_span();
        @(posedge clk); #1;
        push_exp(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);
        drive_word(64'h7DEA_DBEE_FCAF_EF00, 1'b1, 1'b0, 7'd64);
        drive_word(64'hD000_0000_0000_0000, 1'b0, 1'b1, 7'd4);
        n_vec++;
        if (out_valid_o !== 1'b0) begin
            n_miss++;
            $display("FAIL raw_latency_early got valid=%b at accept edge, want 0", out_valid_o);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid_o !== 1'b1) begin
            n_miss++;
            $display("FAIL raw_latency got valid=%b one edge after accept, want 1", out_valid_o);
        end
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL raw_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_mixed_backpressure();
        logic [3:0]  m;
        logic [63:0] d;
        pkt_words.delete();
        for (int i = 0; i < 20; i++) begin
            m = 4'(i % 16);
            d = '0;
            for (int k = 0; k < 4; k++)
                if (m[k]) d[16*k +: 16] = 16'($urandom_range(1, 65535));
            pkt_words.push_back(d);
        end
        build_packet(1'b1);
        @(posedge clk); #1;
        fork
            send_stream();
            begin
                logic        saw_low;
                logic        stable;
                logic [65:0] held;
                int          seen;
                saw_low = 1'b0;
                stable  = 1'b1;
                held    = '0;
                seen    = 0;
                repeat (4) @(posedge clk);
                #2 out_ready_i = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (!in_ready_o) saw_low = 1'b1;
                    if (out_valid_o) begin
                        if (seen == 0) held = {out_data_o, out_sop_o, out_eop_o};
                        else if ({out_data_o, out_sop_o, out_eop_o} !== held) stable = 1'b0;
                        seen++;
                    end
                end
                @(posedge clk);
                #2 out_ready_i = 1'b1;
                n_vec++;
                if (saw_low !== 1'b1) begin
                    n_miss++;
                    $display("FAIL stall_in_ready got never low during stall, want low");
                end
                n_vec++;
                if (stable !== 1'b1 || seen == 0) begin
                    n_miss++;
                    $display("FAIL stall_hold got stable=%b valid_cycles=%0d, want stable=1 cycles>0", stable, seen);
                end
            end
        join
        wait_drain(300);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL mixed_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_truncated();
        int errs;
        errs = 0;
        pkt_words.delete();
        pkt_words.push_back(64'h0);
        pkt_words.push_back(64'h0);
        pkt_words.push_back(64'h0);
        pkt_words.push_back(64'h0000_0000_0000_0ABC);
        pkt_words.push_back(64'h0000_0000_0000_0001);
        build_packet(1'b0);
        push_bits(64'h0, 3);
        @(posedge clk); #1;
        fork
            send_stream();
            repeat (40) begin
                @(negedge clk);
                if (err_o) errs++;
            end
        join
        n_vec++;
        if (errs != 1) begin
            n_miss++;
            $display("FAIL truncated_err got %0d err cycles, want 1", errs);
        end
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL truncated_drain got %0d pending, want 0", exp_q.size());
        end
        @(posedge clk); #1;
        push_exp(64'h0000_0000_0000_1234, 1'b1, 1'b1);
        drive_word(64'h4112_3400_0000_0000, 1'b1, 1'b1, 7'd24);
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL after_error_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_body();
        logic [63:0] w0;
        logic [63:0] w1;
        pkt_words.delete();
        for (int i = 0; i < 20; i++)
            pkt_words.push_back({16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)),
                                 16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))});
        build_packet(1'b1);
        for (int b = 0; b < 64; b++) begin
            w0[63-b] = stream_q[b];
            w1[63-b] = stream_q[64+b];
        end
        @(posedge clk); #1;
        drive_word(w0, 1'b1, 1'b0, 7'd64);
        drive_word(w1, 1'b0, 1'b0, 7'd64);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        stream_q.delete();
        #1;
        n_vec++;
        if ({out_valid_o, out_sop_o, out_eop_o, err_o, out_data_o} !== 68'h0) begin
            n_miss++;
            $display("FAIL midreset_outputs got v=%b s=%b e=%b err=%b d=%h, want all 0",
                     out_valid_o, out_sop_o, out_eop_o, err_o, out_data_o);
        end
        n_vec++;
        if (in_ready_o !== 1'b1) begin
            n_miss++;
            $display("FAIL midreset_ready got %b, want 1", in_ready_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);
        drive_word(64'h7DEA_DBEE_FCAF_EF00, 1'b1, 1'b0, 7'd64);
        drive_word(64'hD000_0000_0000_0000, 1'b0, 1'b1, 7'd4);
        wait_drain(20);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL after_reset_drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_packet();
        test_l0_packet();
        test_raw_span();
        test_mixed_backpressure();
        test_truncated();
        test_reset_mid_body();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
